// File: rtl/fxu_pkg.sv
// Shared fixed-point unit definitions: data/tag widths and opcode encodings,
// reused by the reservation stations and the ROB as well as the FXU itself.
package fxu_pkg;

  localparam int DATA_W    = 16;
  localparam int ROB_IDX_W = 4;
  localparam int IMM_W     = 8;
  localparam int OPC_W     = 4;
  localparam int SHAMT_W   = $clog2(DATA_W);

  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_MOVL = 4'b1000;
  localparam logic [OPC_W-1:0] OP_MOVH = 4'b1001;

  // One Common Data Bus lane as seen by the ROB and every reservation station.
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] index;
    logic [DATA_W-1:0]    value;
  } cdb_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fxu_alu.sv
// Combinational datapath of the fixed-point unit: opcode, operands, immediate -> result.
// The MUL opcode is implemented only when FXU_MUL_EN is defined.
module fxu_alu
  import fxu_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] op1_value,
  input  logic [DATA_W-1:0] op2_value,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result
);

  logic [SHAMT_W-1:0] w_shamt;
  logic [DATA_W-1:0]  w_movh;

  // Only the low bits of operand B select the shift distance.
  assign w_shamt = op2_value[SHAMT_W-1:0];
  assign w_movh  = {imm, op1_value[DATA_W-IMM_W-1:0]};

`ifdef FXU_MUL_EN
  logic [DATA_W-1:0] w_product;
  assign w_product = op1_value * op2_value;
`endif

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    result = '0;
    case (opcode)
      OP_SUB:  result = op1_value - op2_value;
      OP_ADD:  result = op1_value + op2_value;
      OP_AND:  result = op1_value & op2_value;
      OP_OR:   result = op1_value | op2_value;
      OP_XOR:  result = op1_value ^ op2_value;
      OP_SHL:  result = op1_value << w_shamt;
      OP_SHR:  result = op1_value >> w_shamt;
`ifdef FXU_MUL_EN
      OP_MUL:  result = w_product;
`endif
      OP_MOVL: result = sext_imm(imm);
      OP_MOVH: result = w_movh;
      // Undefined opcodes still broadcast their tag so the ROB can retire it.
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/fxu_exec_unit.sv
// Fixed-point execution unit: one issue per cycle, result on the CDB lane one cycle later.
// Optional MUL opcode enabled by defining FXU_MUL_EN.
module fxu_exec_unit
  import fxu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPC_W-1:0]     opcode,
  input  logic [ROB_IDX_W-1:0] instr_index,
  input  logic                 valid,
  input  logic [DATA_W-1:0]    op1_value,
  input  logic [DATA_W-1:0]    op2_value,
  input  logic [IMM_W-1:0]     imm,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_index,
  output logic [DATA_W-1:0]    cdb_value
);

  logic [DATA_W-1:0] w_result;
  cdb_t              r_cdb;

  fxu_alu u_alu (
    .opcode    (opcode),
    .op1_value (op1_value),
    .op2_value (op2_value),
    .imm       (imm),
    .result    (w_result)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb <= '0;
    end else begin
      r_cdb.valid <= valid;
      // Tag and value only load on an issue; consumers ignore them while valid is low.
      if (valid) begin
        r_cdb.index <= instr_index;
        r_cdb.value <= w_result;
      end
    end
  end

  assign cdb_valid = r_cdb.valid;
  assign cdb_index = r_cdb.index;
  assign cdb_value = r_cdb.value;

endmodule

// File: tb/tb_fxu_exec_unit.sv
// Self-checking bench for fxu_exec_unit: arithmetic reference model checked every cycle,
// plus hand-computed expectations for the key cases.
module tb_fxu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = '0;
  logic [3:0]  instr_index = '0;
  logic        valid = 1'b0;
  logic [15:0] op1_value = '0;
  logic [15:0] op2_value = '0;
  logic [7:0]  imm = '0;
  logic        cdb_valid;
  logic [3:0]  cdb_index;
  logic [15:0] cdb_value;

  int n_tests = 0;
  int n_fail  = 0;

  fxu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .instr_index (instr_index),
    .valid       (valid),
    .op1_value   (op1_value),
    .op2_value   (op2_value),
    .imm         (imm),
    .cdb_valid   (cdb_valid),
    .cdb_index   (cdb_index),
    .cdb_value   (cdb_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics written as plain integer arithmetic modulo 65536.
  function automatic int model_result(input int opc, input int a, input int b, input int im);
    int sh;
    sh = b % 16;
    case (opc)
      0:  return (a - b + 65536) % 65536;
      1:  return (a + b) % 65536;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return (a * (1 << sh)) % 65536;
      6:  return a / (1 << sh);
`ifdef FXU_MUL_EN
      7:  return int'((longint'(a) * longint'(b)) % 65536);
`endif
      8:  return (im >= 128) ? (im + 65280) : im;
      9:  return im * 256 + (a % 256);
      default: return 0;
    endcase
  endfunction

  // Model of what the CDB lane must show after each edge.
  int m_valid, m_index, m_value;
  bit model_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid     <= 0;
      m_index     <= 0;
      m_value     <= 0;
      model_known <= 1'b1;
    end else begin
      m_valid <= int'(valid);
      if (valid) begin
        m_index <= int'(instr_index);
        m_value <= model_result(int'(opcode), int'(op1_value), int'(op2_value), int'(imm));
      end
    end
  end

  always @(negedge clk) begin
    if (model_known) begin
      check("model cdb_valid", 32'(cdb_valid), 32'(m_valid));
      check("model cdb_index", 32'(cdb_index), 32'(m_index));
      check("model cdb_value", 32'(cdb_value), 32'(m_value));
    end
  end

  // Apply inputs just after an edge; return just after the edge that samples them.
  task automatic drive(input logic v, input logic [3:0] opc, input logic [3:0] idx,
                       input logic [15:0] a, input logic [15:0] b, input logic [7:0] im);
    valid       = v;
    opcode      = opc;
    instr_index = idx;
    op1_value   = a;
    op2_value   = b;
    imm         = im;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cdb(input string name, input logic v, input logic [3:0] idx,
                            input logic [15:0] val);
    check({name, " valid"}, 32'(cdb_valid), 32'(v));
    check({name, " index"}, 32'(cdb_index), 32'(idx));
    check({name, " value"}, 32'(cdb_value), 32'(val));
  endtask

  logic [15:0] sweep_a [4] = '{16'h0003, 16'hFFFF, 16'h8001, 16'h1234};
  logic [15:0] sweep_b [4] = '{16'h0005, 16'h0002, 16'h001F, 16'hF0F7};
  logic [7:0]  sweep_i [4] = '{8'h80, 8'h12, 8'h7F, 8'hAB};

  initial begin
    @(posedge clk);
    #1;
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 8'h0);
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 8'h0);
    expect_cdb("reset idle", 1'b0, 4'h0, 16'h0000);
    rst = 1'b0;

    drive(1'b1, 4'b0001, 4'h5, 16'h0001, 16'h0002, 8'h00);
    expect_cdb("pre-reset add", 1'b1, 4'h5, 16'h0003);

    // Reset wins over a simultaneous issue.
    rst = 1'b1;
    drive(1'b1, 4'b0001, 4'h6, 16'h0010, 16'h0020, 8'h00);
    expect_cdb("reset drops issue", 1'b0, 4'h0, 16'h0000);
    rst = 1'b0;

    drive(1'b1, 4'b0000, 4'h7, 16'h0003, 16'h0005, 8'h00);
    expect_cdb("sub wrap", 1'b1, 4'h7, 16'hFFFE);

    drive(1'b1, 4'b1000, 4'h3, 16'h5555, 16'hAAAA, 8'h80);
    expect_cdb("movl neg", 1'b1, 4'h3, 16'hFF80);
    drive(1'b1, 4'b1000, 4'h4, 16'h5555, 16'hAAAA, 8'h12);
    expect_cdb("movl pos", 1'b1, 4'h4, 16'h0012);
    drive(1'b1, 4'b1001, 4'h8, 16'h1234, 16'h0000, 8'hAB);
    expect_cdb("movh", 1'b1, 4'h8, 16'hAB34);

    drive(1'b1, 4'b0001, 4'h1, 16'hFFFF, 16'h0002, 8'h00);
    expect_cdb("b2b add", 1'b1, 4'h1, 16'h0001);
    drive(1'b1, 4'b0110, 4'h2, 16'h8000, 16'h0013, 8'h00);
    expect_cdb("b2b shr", 1'b1, 4'h2, 16'h1000);
    drive(1'b0, 4'b0001, 4'hE, 16'h1111, 16'h2222, 8'h00);
    check("idle valid", 32'(cdb_valid), 32'h0);
    check("idle holds value", 32'(cdb_value), 32'h1000);

    drive(1'b1, 4'b1100, 4'h9, 16'h1234, 16'h5678, 8'hFF);
    expect_cdb("undef opcode", 1'b1, 4'h9, 16'h0000);

    drive(1'b1, 4'b0111, 4'hA, 16'h0100, 16'h0101, 8'h00);
`ifdef FXU_MUL_EN
    expect_cdb("mul", 1'b1, 4'hA, 16'h0100);
`else
    expect_cdb("mul disabled", 1'b1, 4'hA, 16'h0000);
`endif

    drive(1'b1, 4'b0101, 4'hB, 16'h0001, 16'h0011, 8'h00);
    expect_cdb("shl upper bits ignored", 1'b1, 4'hB, 16'h0002);
    drive(1'b1, 4'b0110, 4'hC, 16'h8000, 16'h000F, 8'h00);
    expect_cdb("shr max", 1'b1, 4'hC, 16'h0001);

    // Every opcode against a few operand patterns, with occasional bubbles.
    for (int opc = 0; opc < 16; opc++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 4'(opc), 4'(opc + k), sweep_a[k], sweep_b[k], sweep_i[k]);
        if (k == 2) drive(1'b0, 4'(opc), 4'hF, 16'hDEAD, 16'hBEEF, 8'h5A);
      end
    end

    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 8'h0);
    drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 8'h0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
